// File: rtl/btn_event.sv
// Press classifier behind the button debouncer: short/long/auto-repeat single-cycle pulses.
// Optional auto-repeat enabled by defining BTN_REPEAT_EN. LONG_CNT and REP_CNT must both be >= 2.
module btn_event #(
  parameter int CLK_FREQ  = 125000000,
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_db,
  output logic       short_pulse,
  output logic       long_pulse,
  output logic       rep_pulse,
  output logic       held,
  output logic [7:0] evt_count
);

  localparam int LONG_CNT = (CLK_FREQ / 1000) * LONG_MS;
  localparam int REP_CNT  = (CLK_FREQ / 1000) * REPEAT_MS;
  localparam logic [31:0] LONG_LIM = 32'(LONG_CNT - 1);
  localparam logic [31:0] REP_LIM  = 32'(REP_CNT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESSED   = 2'd1,
    LONG_HELD = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] cnt_reg, cnt_next;
  logic        armed_reg, armed_next;
  logic        short_reg, short_next;
  logic        long_reg, long_next;
  logic        rep_reg, rep_next;
  logic [7:0]  evt_reg, evt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      armed_reg <= 1'b0;
      short_reg <= 1'b0;
      long_reg  <= 1'b0;
      rep_reg   <= 1'b0;
      evt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      armed_reg <= armed_next;
      short_reg <= short_next;
      long_reg  <= long_next;
      rep_reg   <= rep_next;
      evt_reg   <= evt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    armed_next = armed_reg;
    short_next = 1'b0;
    long_next  = 1'b0;
    rep_next   = 1'b0;
    evt_next   = evt_reg;
    case (state_reg)
      IDLE: begin
        // A press still held across reset is discarded until the button is seen released.
        if (!armed_reg) begin
          if (!btn_db) armed_next = 1'b1;
        end else if (btn_db) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end
      end
      PRESSED: begin
        if (!btn_db) begin
          short_next = 1'b1;
          evt_next   = evt_reg + 8'd1;
          state_next = IDLE;
        end else if (cnt_reg == LONG_LIM) begin
          long_next  = 1'b1;
          evt_next   = evt_reg + 8'd1;
          state_next = LONG_HELD;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
      end
      LONG_HELD: begin
        if (!btn_db) begin
          state_next = IDLE;
        end
`ifdef BTN_REPEAT_EN
        else if (cnt_reg == REP_LIM) begin
          rep_next = 1'b1;
          cnt_next = '0;
        end else begin
          cnt_next = cnt_reg + 32'd1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

  assign short_pulse = short_reg;
  assign long_pulse  = long_reg;
  assign rep_pulse   = rep_reg;
  assign held        = (state_reg != IDLE);
  assign evt_count   = evt_reg;

endmodule

// File: tb/tb_btn_event.sv
// Bench for btn_event: table of press lengths with a scoreboard queue, plus hand-written
// sequences for back-to-back presses, event-counter wrap and reset mid-press.
module tb_btn_event;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_db = 1'b0;
  logic       short_pulse, long_pulse, rep_pulse, held;
  logic [7:0] evt_count;

  btn_event #(.CLK_FREQ(1000), .LONG_MS(10), .REPEAT_MS(3)) dut (
    .clk(clk), .rst(rst), .btn_db(btn_db),
    .short_pulse(short_pulse), .long_pulse(long_pulse), .rep_pulse(rep_pulse),
    .held(held), .evt_count(evt_count)
  );

  always #5 clk = ~clk;

`ifdef BTN_REPEAT_EN
  localparam int REP30 = 6;   // reps at +3..+18 after long_pulse for a 30-cycle hold
  localparam int REPOFF = 13;
`else
  localparam int REP30 = 0;
  localparam int REPOFF = -1;
`endif

  typedef struct {
    int hold;
    int gap;
    int exp_short;
    int exp_long;
    int exp_rep;
    int exp_held;
    int exp_off;
    int exp_rep_off;
  } vec_t;

  vec_t vecs[6];
  vec_t sb[$];

  int n_checks = 0;
  int n_fail = 0;
  int exp_evt = 0;

  // monitor state
  int stp, held_rise, held_cycles, pulse_off, rep_off;
  int short_cnt, long_cnt, rep_cnt, mutex_bad, any_out;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_mon();
    stp = 0; held_rise = -1; held_cycles = 0; pulse_off = -1; rep_off = -1;
    short_cnt = 0; long_cnt = 0; rep_cnt = 0; mutex_bad = 0; any_out = 0;
  endtask

  task automatic step(input logic b);
    btn_db = b;
    @(posedge clk);
    #1;
    if (held) begin
      held_cycles++;
      if (held_rise < 0) held_rise = stp;
    end
    if ((short_pulse || long_pulse) && pulse_off < 0) pulse_off = stp - held_rise;
    if (rep_pulse && rep_off < 0) rep_off = stp - held_rise;
    short_cnt += int'(short_pulse);
    long_cnt  += int'(long_pulse);
    rep_cnt   += int'(rep_pulse);
    if (int'(short_pulse) + int'(long_pulse) + int'(rep_pulse) > 1) mutex_bad++;
    if (short_pulse || long_pulse || rep_pulse || held || evt_count != 8'd0) any_out++;
    stp++;
  endtask

  task automatic run_press(input int hold, input int gap);
    clear_mon();
    for (int j = 0; j < hold; j++) step(1'b1);
    for (int j = 0; j < gap; j++) step(1'b0);
    $display("press hold=%0d gap=%0d short=%0d long=%0d rep=%0d held=%0d evt=%0d",
             hold, gap, short_cnt, long_cnt, rep_cnt, held_cycles, evt_count);
  endtask

  task automatic score();
    vec_t e;
    e = sb.pop_front();
    exp_evt = (exp_evt + e.exp_short + e.exp_long) % 256;
    check($sformatf("short_cnt h%0d", e.hold), short_cnt, e.exp_short);
    check($sformatf("long_cnt h%0d", e.hold), long_cnt, e.exp_long);
    check($sformatf("rep_cnt h%0d", e.hold), rep_cnt, e.exp_rep);
    check($sformatf("held_cycles h%0d", e.hold), held_cycles, e.exp_held);
    check($sformatf("pulse_off h%0d", e.hold), pulse_off, e.exp_off);
    check($sformatf("rep_off h%0d", e.hold), rep_off, e.exp_rep_off);
    check($sformatf("mutex h%0d", e.hold), mutex_bad, 0);
    check($sformatf("evt_count h%0d", e.hold), int'(evt_count), exp_evt);
  endtask

  initial begin
    int tot_short;
    int tot_long;

    vecs[0] = '{hold: 1,  gap: 4, exp_short: 1, exp_long: 0, exp_rep: 0,     exp_held: 1,  exp_off: 1,  exp_rep_off: -1};
    vecs[1] = '{hold: 5,  gap: 4, exp_short: 1, exp_long: 0, exp_rep: 0,     exp_held: 5,  exp_off: 5,  exp_rep_off: -1};
    vecs[2] = '{hold: 9,  gap: 4, exp_short: 1, exp_long: 0, exp_rep: 0,     exp_held: 9,  exp_off: 9,  exp_rep_off: -1};
    vecs[3] = '{hold: 10, gap: 4, exp_short: 1, exp_long: 0, exp_rep: 0,     exp_held: 10, exp_off: 10, exp_rep_off: -1};
    vecs[4] = '{hold: 11, gap: 4, exp_short: 0, exp_long: 1, exp_rep: 0,     exp_held: 11, exp_off: 10, exp_rep_off: -1};
    vecs[5] = '{hold: 30, gap: 4, exp_short: 0, exp_long: 1, exp_rep: REP30, exp_held: 30, exp_off: 10, exp_rep_off: REPOFF};

    // reset state
    rst = 1'b1;
    clear_mon();
    step(1'b1);
    step(1'b1);
    check("reset short", int'(short_pulse), 0);
    check("reset long", int'(long_pulse), 0);
    check("reset rep", int'(rep_pulse), 0);
    check("reset held", int'(held), 0);
    check("reset evt", int'(evt_count), 0);
    rst = 1'b0;
    step(1'b0);

    // table-driven presses
    for (int i = 0; i < 6; i++) begin
      sb.push_back(vecs[i]);
      run_press(vecs[i].hold, vecs[i].gap);
      score();
    end

    // back-to-back: 3-cycle press, single 0 cycle, 3-cycle press
    clear_mon();
    step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    step(1'b1); step(1'b1); step(1'b1); step(1'b0);
    step(1'b0); step(1'b0);
    exp_evt = (exp_evt + 2) % 256;
    $display("back-to-back short=%0d long=%0d evt=%0d", short_cnt, long_cnt, evt_count);
    check("b2b short_cnt", short_cnt, 2);
    check("b2b long_cnt", long_cnt, 0);
    check("b2b held_cycles", held_cycles, 6);
    check("b2b evt_count", int'(evt_count), exp_evt);

    // wrap-around from a fresh reset
    rst = 1'b1;
    step(1'b0);
    rst = 1'b0;
    step(1'b0);
    exp_evt = 0;
    tot_short = 0;
    tot_long = 0;
    for (int i = 0; i < 256; i++) begin
      run_press(2, 1);
      tot_short += short_cnt;
      tot_long  += long_cnt;
      if (i == 254) check("evt_count at 255", int'(evt_count), 255);
    end
    check("wrap evt_count", int'(evt_count), 0);
    check("wrap short total", tot_short, 256);
    check("wrap long total", tot_long, 0);

    // reset mid-press: press discarded, button ignored until seen released
    exp_evt = 0;
    clear_mon();
    for (int j = 0; j < 5; j++) step(1'b1);
    rst = 1'b1;
    step(1'b1);
    rst = 1'b0;
    clear_mon();
    for (int j = 0; j < 20; j++) step(1'b1);
    for (int j = 0; j < 3; j++) step(1'b0);
    $display("reset mid-press short=%0d long=%0d held=%0d active=%0d",
             short_cnt, long_cnt, held_cycles, any_out);
    check("midrst outputs active", any_out, 0);
    check("midrst evt_count", int'(evt_count), 0);
    sb.push_back(vecs[1]);
    run_press(vecs[1].hold, vecs[1].gap);
    score();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/btn_event.md
# btn_event

Press classifier sitting directly downstream of the button debouncer. Consumes the clean, debounced button level and converts it into single-cycle command pulses: short press on release, long press on hold, and optional auto-repeat while held. These pulses drive TRNG capture and UART send control. All outputs are registered and change only on `clk` rising edges.

## Interface
**Parameters**
- `CLK_FREQ`, 125000000: clock frequency in Hz.
- `LONG_MS`, 1000: hold time in ms that classifies a press as long.
- `REPEAT_MS`, 200: auto-repeat period in ms. Used only when `BTN_REPEAT_EN` is defined.
- Derived values: `LONG_CNT = (CLK_FREQ/1000)*LONG_MS` and `REP_CNT = (CLK_FREQ/1000)*REPEAT_MS`. Both must be ≥ 2; this is a documented elaboration constraint.

**Ports**
- `clk` in 1: system clock.
- `rst` in 1: reset; synchronous and active-high.
- `btn_db` in 1: debounced button level, already synchronous to `clk`. 1 = pressed.
- `short_pulse` out 1: one-cycle pulse when the button is released before `LONG_CNT` is reached.
- `long_pulse` out 1: one-cycle pulse when the hold reaches `LONG_CNT`.
- `rep_pulse` out 1: one-cycle auto-repeat pulse. Tied to 0 without `BTN_REPEAT_EN`.
- `held` out 1: high while the state is PRESSED or LONG_HELD.
- `evt_count` out 8: count of `short_pulse` + `long_pulse` events. Wraps from 255 to 0.

## Operation
- **States:** IDLE, PRESSED, LONG_HELD. A 32-bit cycle counter `cnt`.
- **Reset:** state = IDLE, `cnt` = 0, every output = 0, including `evt_count`. Reset overrides every other event on the same edge. A reset mid-press discards the press: no pulse is emitted, and the block ignores `btn_db` until `btn_db` has been sampled at 0 at least once after reset.
- **IDLE:**
  - `btn_db`=1 → go to PRESSED, set `cnt` ← 0.
  - `btn_db`=0 → stay in IDLE.
- **PRESSED**, in priority order:
  - `btn_db`=0 → `short_pulse` ← 1, go to IDLE.
  - `cnt`==`LONG_CNT`-1 → `long_pulse` ← 1, go to LONG_HELD, `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
- **LONG_HELD:**
  - `btn_db`=0 → go to IDLE. No pulse is emitted on release.
  - Otherwise apply the repeat behaviour described under Configuration. Without repeat, `cnt` holds.
- **Mutual exclusion:** at most one of `short_pulse`, `long_pulse` and `rep_pulse` is high in any cycle. Every pulse lasts exactly one cycle.
- **Event counter:** `evt_count` increments on the same edge that asserts `short_pulse` or `long_pulse`. `rep_pulse` does not increment it.
- **Counter width:** `cnt` never exceeds max(`LONG_CNT`, `REP_CNT`)-1, so it cannot overflow.

## Timing
- Define edge E0 as the edge that samples `btn_db`=1 in IDLE. `held` is high from E0+1, meaning after E0.
- **Long press:** `long_pulse` is high for the cycle following edge E0+`LONG_CNT`, i.e. `LONG_CNT` cycles after `held` rises.
- **Short press:** if `btn_db` is sampled 0 at edge Ek with 1 ≤ k ≤ `LONG_CNT`, `short_pulse` is high for the cycle after Ek, and `held` falls on the same edge.
- **Simultaneous release and long-threshold:** release wins, so `short_pulse` is emitted.
- **Back-to-back presses:** a release followed by a re-press one cycle later is accepted. The IDLE state costs one cycle, so the minimum gap is 1 cycle of `btn_db`=0.
- **Latency:** input to output latency is 1 cycle, with no combinational paths from input to output.

## Configuration
- **`BTN_REPEAT_EN` defined:** in LONG_HELD with `btn_db`=1:
  - `cnt`==`REP_CNT`-1 → `rep_pulse` ← 1, `cnt` ← 0.
  - Otherwise `cnt` ← `cnt`+1.
  - First `rep_pulse` fires `REP_CNT` cycles after `long_pulse`, then every `REP_CNT` cycles.
- **`BTN_REPEAT_EN` undefined:** `rep_pulse` is constant 0, the repeat logic is absent, and LONG_HELD simply waits for release.

## Test plan
All scenarios use `CLK_FREQ`=1000, `LONG_MS`=10, `REPEAT_MS`=3, giving `LONG_CNT`=10 and `REP_CNT`=3.
- **Short press:** hold `btn_db`=1 for 5 cycles, then 0 → exactly one `short_pulse`, no `long_pulse`, `evt_count`=1, `held` high for 5 cycles.
- **Long press:** hold `btn_db`=1 for 30 cycles → `long_pulse` 10 cycles after `held` rises. With `BTN_REPEAT_EN`, `rep_pulse` occurs at +3, +6, … after it. On release, no `short_pulse` is emitted. `evt_count`=1.
- **Boundary:** release on the exact cycle the long threshold is reached (k=10) → `short_pulse` only. Release at k=11 → `long_pulse` only.
- **Wrap-around:** 256 short presses → `evt_count` returns to 0, with one pulse per press.
- **Reset mid-press:** assert `rst` for 1 cycle at hold cycle 5 while `btn_db` stays 1 for 20 more cycles → all outputs stay 0. The next genuine press works normally.
- **Back-to-back:** 3-cycle press, 1 cycle of 0, 3-cycle press → two `short_pulse` events, `evt_count`=2.
